// File: rtl/mmio_if.sv
// rtl/mmio_if.sv - MMIO register bus shared by the DMA channel map and its host
//
// Purpose: single-cycle MMIO write port plus a read port whose data returns
//          one cycle after rd_en.
// Signals: wr_en, wr_addr[15:0], wr_data[63:0]  write request
//          rd_en, rd_addr[15:0]                 read request
//          rd_data[63:0]                        read response
// Modports: user (register block side), host (bus master side).
interface mmio_if;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [63:0] wr_data;
  logic        rd_en;
  logic [15:0] rd_addr;
  logic [63:0] rd_data;

  modport user (input wr_en, wr_addr, wr_data, rd_en, rd_addr, output rd_data);
  modport host (output wr_en, wr_addr, wr_data, rd_en, rd_addr, input rd_data);
endinterface

// File: rtl/mmio_dma_channel_map.sv
// rtl/mmio_dma_channel_map.sv - MMIO register map driving NUM_CHANNELS DMA channels
//
// Purpose: per-channel CTRL/RD_ADDR/WR_ADDR/SIZE/STATUS/CYCLES registers at
//          BASE_ADDR + c*STRIDE + offset, plus global ID (0x0040) and
//          DONE_MASK (0x0042). Each channel runs IDLE -> BUSY -> DONE.
// Ports:   clk, rst_n   clock, synchronous active-low reset
//          mmio         MMIO register port (mmio_if.user)
//          rd_addr      per-channel DMA read start byte address
//          wr_addr      per-channel DMA write start byte address
//          size         per-channel transfer length in cache lines
//          go           per-channel one-cycle start pulse
//          done         per-channel completion level from the DMA engine
// Option:  MMIO_DMA_CYCLE_COUNT_EN adds a saturating 32-bit BUSY-cycle counter
//          per channel, readable at CYCLES; without it CYCLES reads 0.
module mmio_dma_channel_map #(
  parameter int          ADDR_WIDTH   = 64,
  parameter int          SIZE_WIDTH   = 32,
  parameter int          NUM_CHANNELS = 4,
  parameter logic [15:0] BASE_ADDR    = 16'h0050,
  parameter logic [15:0] STRIDE       = 16'h0010
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  mmio_if.user                                    mmio,
  output logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] wr_addr,
  output logic [NUM_CHANNELS-1:0][SIZE_WIDTH-1:0] size,
  output logic [NUM_CHANNELS-1:0]                 go,
  input  logic [NUM_CHANNELS-1:0]                 done
);

  localparam logic [3:0]  OFF_CTRL    = 4'h0;
  localparam logic [3:0]  OFF_RD_ADDR = 4'h2;
  localparam logic [3:0]  OFF_WR_ADDR = 4'h4;
  localparam logic [3:0]  OFF_SIZE    = 4'h6;
  localparam logic [3:0]  OFF_STATUS  = 4'h8;
  localparam logic [3:0]  OFF_CYCLES  = 4'hA;
  localparam logic [15:0] ID_ADDR        = 16'h0040;
  localparam logic [15:0] DONE_MASK_ADDR = 16'h0042;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e                                  state_q [NUM_CHANNELS];
  state_e                                  state_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [NUM_CHANNELS-1:0][SIZE_WIDTH-1:0] size_q, size_d;
  logic [NUM_CHANNELS-1:0]                 go_q, go_d;
  logic [63:0]                             rd_data_q, rd_data_d;
`ifdef MMIO_DMA_CYCLE_COUNT_EN
  logic [NUM_CHANNELS-1:0][31:0]           cyc_q, cyc_d;
`endif

  function automatic logic [15:0] reg_addr(input int ch, input logic [3:0] off);
    return BASE_ADDR + STRIDE * 16'(ch) + {12'h000, off};
  endfunction

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    size_d    = size_q;
    go_d      = '0;
    rd_data_d = rd_data_q;
`ifdef MMIO_DMA_CYCLE_COUNT_EN
    cyc_d     = cyc_q;
`endif

    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (state_q[c] != S_BUSY) begin
        // IDLE and DONE accept configuration and a new start identically.
        if (mmio.wr_en && mmio.wr_addr == reg_addr(c, OFF_RD_ADDR))
          rd_addr_d[c] = mmio.wr_data[ADDR_WIDTH-1:0];
        if (mmio.wr_en && mmio.wr_addr == reg_addr(c, OFF_WR_ADDR))
          wr_addr_d[c] = mmio.wr_data[ADDR_WIDTH-1:0];
        if (mmio.wr_en && mmio.wr_addr == reg_addr(c, OFF_SIZE))
          size_d[c] = mmio.wr_data[SIZE_WIDTH-1:0];

        if (mmio.wr_en && mmio.wr_addr == reg_addr(c, OFF_CTRL) && mmio.wr_data[0]) begin
          if (size_q[c] == '0) begin
            // Nothing to move: complete immediately without bothering the engine.
            state_d[c] = S_DONE;
          end else begin
            state_d[c] = S_BUSY;
            go_d[c]    = 1'b1;
`ifdef MMIO_DMA_CYCLE_COUNT_EN
            cyc_d[c]   = '0;
`endif
          end
        end else if (state_q[c] == S_DONE && mmio.wr_en &&
                     mmio.wr_addr == reg_addr(c, OFF_STATUS) && mmio.wr_data[0]) begin
          state_d[c] = S_IDLE;
        end
      end else if (!go_q[c]) begin
        // go_q high marks the go cycle: a done level there is stale from the
        // previous transfer, so both completion and counting start afterwards.
        if (done[c])
          state_d[c] = S_DONE;
`ifdef MMIO_DMA_CYCLE_COUNT_EN
        if (cyc_q[c] != 32'hFFFF_FFFF)
          cyc_d[c] = cyc_q[c] + 32'd1;
`endif
      end
    end

    // Reads see only pre-edge state, so a same-cycle write is not visible yet.
    if (mmio.rd_en) begin
      rd_data_d = '0;
      if (mmio.rd_addr == ID_ADDR)
        rd_data_d[3:0] = 4'(NUM_CHANNELS);
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (mmio.rd_addr == DONE_MASK_ADDR)
          rd_data_d[c] = (state_q[c] == S_DONE);
        if (mmio.rd_addr == reg_addr(c, OFF_RD_ADDR))
          rd_data_d = 64'(rd_addr_q[c]);
        if (mmio.rd_addr == reg_addr(c, OFF_WR_ADDR))
          rd_data_d = 64'(wr_addr_q[c]);
        if (mmio.rd_addr == reg_addr(c, OFF_SIZE))
          rd_data_d = 64'(size_q[c]);
        if (mmio.rd_addr == reg_addr(c, OFF_STATUS))
          rd_data_d[1:0] = {state_q[c] == S_BUSY, state_q[c] == S_DONE};
`ifdef MMIO_DMA_CYCLE_COUNT_EN
        if (mmio.rd_addr == reg_addr(c, OFF_CYCLES))
          rd_data_d = 64'(cyc_q[c]);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CHANNELS; c++)
        state_q[c] <= S_IDLE;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      size_q    <= '0;
      go_q      <= '0;
      rd_data_q <= '0;
`ifdef MMIO_DMA_CYCLE_COUNT_EN
      cyc_q     <= '0;
`endif
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++)
        state_q[c] <= state_d[c];
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      size_q    <= size_d;
      go_q      <= go_d;
      rd_data_q <= rd_data_d;
`ifdef MMIO_DMA_CYCLE_COUNT_EN
      cyc_q     <= cyc_d;
`endif
    end
  end

  assign rd_addr      = rd_addr_q;
  assign wr_addr      = wr_addr_q;
  assign size         = size_q;
  assign go           = go_q;
  assign mmio.rd_data = rd_data_q;

endmodule

// File: tb/tb_mmio_dma_channel_map.sv
// tb/tb_mmio_dma_channel_map.sv - self-checking bench for mmio_dma_channel_map
module tb_mmio_dma_channel_map;
  localparam int NC = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NC-1:0][63:0]  dut_rd_addr, dut_wr_addr;
  logic [NC-1:0][31:0]  dut_size;
  logic [NC-1:0]        dut_go;
  logic [NC-1:0]        done_in = '0;
  int                   n_checks = 0;
  int                   n_errors = 0;

  mmio_if mif ();

  mmio_dma_channel_map dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mmio    (mif),
    .rd_addr (dut_rd_addr),
    .wr_addr (dut_wr_addr),
    .size    (dut_size),
    .go      (dut_go),
    .done    (done_in)
  );

  always #5 clk = ~clk;

  // Reference model: per-channel configuration plus busy / done-sticky flags.
  logic [63:0] m_rd   [NC];
  logic [63:0] m_wr   [NC];
  logic [31:0] m_size [NC];
  logic [31:0] m_cyc  [NC];
  bit          m_busy [NC];
  bit          m_dst  [NC];
  bit          m_go   [NC];
  logic [63:0] m_rdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      m_rd[i] = '0; m_wr[i] = '0; m_size[i] = '0; m_cyc[i] = '0;
      m_busy[i] = 0; m_dst[i] = 0; m_go[i] = 0;
    end
    m_rdata = '0;
  endtask

  function automatic logic [63:0] m_read(input logic [15:0] a);
    int rel;
    int c;
    logic [63:0] m;
    m = '0;
    if (a == 16'h0040) return 64'(NC);
    if (a == 16'h0042) begin
      for (int i = 0; i < NC; i++) m[i] = m_dst[i];
      return m;
    end
    rel = int'(a) - 'h50;
    if (rel < 0 || rel >= NC * 16) return '0;
    c = rel / 16;
    case (rel % 16)
      2:  return m_rd[c];
      4:  return m_wr[c];
      6:  return 64'(m_size[c]);
      8:  return {62'b0, m_busy[c], m_dst[c]};
`ifdef MMIO_DMA_CYCLE_COUNT_EN
      10: return 64'(m_cyc[c]);
`endif
      default: return '0;
    endcase
  endfunction

  task automatic model_step(input bit rn, input bit we, input logic [15:0] wa,
                            input logic [63:0] wd, input bit re, input logic [15:0] ra,
                            input logic [NC-1:0] dn);
    int  rel, c, off;
    bit  was_go;
    if (!rn) begin
      model_reset();
      return;
    end
    if (re) m_rdata = m_read(ra);
    rel = int'(wa) - 'h50;
    c = -1;
    off = 0;
    if (we && rel >= 0 && rel < NC * 16) begin
      c = rel / 16;
      off = rel % 16;
    end
    for (int i = 0; i < NC; i++) begin
      was_go = m_go[i];
      m_go[i] = 0;
      if (m_busy[i]) begin
        if (!was_go) begin
          if (m_cyc[i] != 32'hFFFF_FFFF) m_cyc[i] = m_cyc[i] + 1;
          if (dn[i]) begin m_busy[i] = 0; m_dst[i] = 1; end
        end
      end else if (c == i) begin
        case (off)
          0: if (wd[0]) begin
               if (m_size[i] == 0) m_dst[i] = 1;
               else begin m_busy[i] = 1; m_dst[i] = 0; m_go[i] = 1; m_cyc[i] = 0; end
             end
          2: m_rd[i] = wd;
          4: m_wr[i] = wd;
          6: m_size[i] = wd[31:0];
          8: if (wd[0]) m_dst[i] = 0;
          default: ;
        endcase
      end
    end
  endtask

  task automatic cycle(input bit we, input logic [15:0] wa, input logic [63:0] wd,
                       input bit re, input logic [15:0] ra, input logic [NC-1:0] dn);
    logic [NC-1:0] gv;
    mif.wr_en = we; mif.wr_addr = wa; mif.wr_data = wd;
    mif.rd_en = re; mif.rd_addr = ra; done_in = dn;
    @(posedge clk);
    #1;
    model_step(rst_n, we, wa, wd, re, ra, dn);
    mif.wr_en = 1'b0; mif.rd_en = 1'b0; done_in = '0;
    for (int i = 0; i < NC; i++) gv[i] = m_go[i];
    check("go", 64'(dut_go), 64'(gv));
    check("rd_data", mif.rd_data, m_rdata);
    for (int i = 0; i < NC; i++) begin
      check($sformatf("rd_addr%0d", i), dut_rd_addr[i], m_rd[i]);
      check($sformatf("wr_addr%0d", i), dut_wr_addr[i], m_wr[i]);
      check($sformatf("size%0d", i), 64'(dut_size[i]), 64'(m_size[i]));
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    cycle(1'b1, a, d, 1'b0, 16'h0, '0);
  endtask

  task automatic rd(input logic [15:0] a);
    cycle(1'b0, 16'h0, 64'h0, 1'b1, a, '0);
  endtask

  task automatic idle(input logic [NC-1:0] dn);
    cycle(1'b0, 16'h0, 64'h0, 1'b0, 16'h0, dn);
  endtask

  function automatic logic [15:0] pick_addr();
    int k;
    int ch;
    k = $urandom_range(0, 15);
    ch = $urandom_range(0, NC);
    if (k < 12) return 16'('h50 + ch * 16 + 2 * $urandom_range(0, 5));
    if (k == 12) return 16'h0040;
    if (k == 13) return 16'h0042;
    if (k == 14) return 16'($urandom);
    return 16'('h50 + ch * 16 + 1 + 2 * $urandom_range(0, 6));
  endfunction

  initial begin
    logic [15:0]   wa, ra;
    logic [63:0]   wd;
    logic [NC-1:0] dn;
    mif.wr_en = 1'b0; mif.wr_addr = '0; mif.wr_data = '0;
    mif.rd_en = 1'b0; mif.rd_addr = '0;
    model_reset();

    rst_n = 1'b0;
    idle('0);
    idle('0);
    check("reset_go", 64'(dut_go), 64'h0);
    check("reset_rd_data", mif.rd_data, 64'h0);
    rst_n = 1'b1;

    // Channel 0 configuration and start
    wr(16'h0052, 64'h1000);
    wr(16'h0054, 64'h2000);
    wr(16'h0056, 64'd8);
    wr(16'h0050, 64'd1);
    check("go0_pulse", 64'(dut_go), 64'h1);
    check("ch0_rd_addr", dut_rd_addr[0], 64'h1000);
    check("ch0_wr_addr", dut_wr_addr[0], 64'h2000);
    check("ch0_size", 64'(dut_size[0]), 64'd8);
    rd(16'h0058);
    check("go0_one_cycle", 64'(dut_go), 64'h0);
    check("ch0_status_busy", mif.rd_data, 64'h2);

    // Channel 1: writes while busy are ignored, then completes
    wr(16'h0066, 64'd3);
    wr(16'h0060, 64'd1);
    check("go1_pulse", 64'(dut_go), 64'h2);
    wr(16'h0066, 64'd5);
    check("ch1_size_locked", 64'(dut_size[1]), 64'd3);
    wr(16'h0060, 64'd1);
    check("ch1_no_rego", 64'(dut_go), 64'h0);
    idle(4'b0010);
    rd(16'h0068);
    check("ch1_status_done", mif.rd_data, 64'h1);
    rd(16'h0042);
    check("done_mask_bit1", 64'(mif.rd_data[1]), 64'h1);

    // Channel 2: zero-size start completes at once, then W1C
    wr(16'h0070, 64'd1);
    check("ch2_no_go", 64'(dut_go), 64'h0);
    rd(16'h0078);
    check("ch2_status_done", mif.rd_data, 64'h1);
    wr(16'h0078, 64'd1);
    rd(16'h0078);
    check("ch2_status_clear", mif.rd_data, 64'h0);
    cycle(1'b1, 16'h0076, 64'd7, 1'b1, 16'h0076, '0);
    check("rd_before_wr", mif.rd_data, 64'h0);
    rd(16'h0076);
    check("ch2_size_after", mif.rd_data, 64'd7);

    // Unmapped and ID reads
    rd(16'h0046);
    check("unmapped_46", mif.rd_data, 64'h0);
    rd(16'h0090);
    check("unmapped_90", mif.rd_data, 64'h0);
    rd(16'h0040);
    check("id", mif.rd_data, 64'd4);

    // Channel 3 cycle count: done ten cycles after the go pulse
    wr(16'h0086, 64'd1);
    wr(16'h0080, 64'd1);
    check("go3_pulse", 64'(dut_go), 64'h8);
    for (int i = 0; i < 10; i++) idle('0);
    idle(4'b1000);
    rd(16'h008A);
`ifdef MMIO_DMA_CYCLE_COUNT_EN
    check("ch3_cycles", mif.rd_data, 64'd10);
`else
    check("ch3_cycles", mif.rd_data, 64'd0);
`endif
    rd(16'h0088);
    check("ch3_status_done", mif.rd_data, 64'h1);

    // Reset while channel 0 is still busy
    rst_n = 1'b0;
    idle('0);
    check("midreset_go", 64'(dut_go), 64'h0);
    check("midreset_rd_data", mif.rd_data, 64'h0);
    rst_n = 1'b1;
    idle(4'b0001);
    rd(16'h0058);
    check("post_reset_status0", mif.rd_data, 64'h0);
    rd(16'h0052);
    check("post_reset_rd_addr0", mif.rd_data, 64'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      wa = pick_addr();
      ra = ($urandom_range(0, 7) == 0) ? wa : pick_addr();
      wd = {$urandom, $urandom};
      if ((wa[3:0] == 4'h6) && $urandom_range(0, 1) == 1) wd = 64'($urandom_range(0, 2));
      for (int i = 0; i < NC; i++) dn[i] = ($urandom_range(0, 5) == 0);
      cycle($urandom_range(0, 2) != 0, wa, wd, $urandom_range(0, 1) == 1, ra, dn);
    end
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
